conv_buf_sched: RTL and testbench
=================================

Name: conv_buf_sched

Overview:
- Sequences the post-convolution layer chain CONV → RELU → POOL over a single shared dual-port conv-buffer BRAM.
- Issues one-cycle start pulses to each stage, waits for its done pulse, and muxes BRAM port A (read) and port B (write) to the active stage.
- Sits between the top-level frame controller and the conv, relu and maxpool engines.

Parameters:
- DATA_WIDTH, 16: sample width, signed.
- CHANNELS, 8: feature-map channels in buffer.
- IMG_SIZE, 28: feature-map height/width.
- TIMEOUT_CYCLES, 65536: per-stage watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  frame start request, pulse
- done  out  1  one-cycle pulse when POOL completes
- busy  out  1  high in any state except IDLE
- stage  out  2  current owner: 0 idle, 1 conv, 2 relu, 3 pool
- conv_start / relu_start / pool_start  out  1 each  one-cycle stage start pulses
- conv_done / relu_done / pool_done  in  1 each  stage completion pulses
- conv_w_addr, conv_w_en, conv_w_we, conv_w_d  in  AW,1,1,DW  conv write request
- relu_r_addr, relu_r_en  in  AW,1  relu read request
- relu_w_addr, relu_w_en, relu_w_we, relu_w_d  in  AW,1,1,DW  relu write request
- pool_r_addr, pool_r_en  in  AW,1  pool read request
- bram_a_addr, bram_a_en  out  AW,1  BRAM port A
- bram_b_addr, bram_b_en, bram_b_we, bram_b_d  out  AW,1,1,DW  BRAM port B
- bram_a_q  in  DW  port A read data
- rd_q  out  DW  broadcast copy of bram_a_q to relu and pool
- (AW = $clog2(CHANNELS*IMG_SIZE*IMG_SIZE), DW = DATA_WIDTH)

Behaviour:
- States: IDLE, CONV, RELU, POOL, FINISH.
- Reset values: state IDLE; done, busy, all *_start, bram_*_en, bram_b_we = 0; stage = 0; addresses and data = 0.
- IDLE→CONV on start. Assert conv_start for exactly the first cycle in CONV.
- CONV→RELU on conv_done. Same pattern for relu_start/relu_done and for RELU→POOL.
- POOL→FINISH on pool_done.
- FINISH: done=1 for one cycle, then →IDLE.
- A done pulse is accepted only from the active stage, and only from the cycle after its start pulse. Done pulses from inactive stages are ignored. A done arriving in the start cycle is ignored.
- start while busy is ignored, with no queueing. start in the FINISH cycle is also ignored.
- Port mux is combinational from the registered state, with zero added latency:
  - CONV: port B ← conv_w_*; port A disabled.
  - RELU: port A ← relu_r_*; port B ← relu_w_*.
  - POOL: port A ← pool_r_*; port B disabled.
  - IDLE/FINISH: both ports disabled.
- A disabled port drives en=0, we=0, addr=0, d=0.
- rd_q = bram_a_q, unconditionally. Read latency is the BRAM's; the sequencer does not modify timing.
- Requests from a non-owner never reach the BRAM, even if their en is asserted.
- Reset mid-frame returns to IDLE within one cycle. No done pulse is emitted. Stage engines share the same reset.
- stage/busy are registered and change on the same edge as the state.

Optional Feature:
- Macro: CONV_BUF_SCHED_TIMEOUT_EN.
- When defined:
  - Adds output err (1 bit, reset 0) and a 32-bit watchdog counter.
  - The counter clears on every stage entry and increments each cycle in CONV/RELU/POOL.
  - If it reaches TIMEOUT_CYCLES before the stage done arrives: go to IDLE, pulse err for 1 cycle, no done.
  - err also clears on reset.
- When undefined: no err port, no counter, and stages wait indefinitely.

Decomposition:
- Shared package cnn_pkg: sched_state_t enum, stage code constants (STG_IDLE=0, STG_CONV=1, STG_RELU=2, STG_POOL=3), and the buffer address-width function.
- One sub-module, bram_port_mux: a purely combinational owner-select for ports A and B.
- The FSM stays in conv_buf_sched.

Test Plan:
- Reset, then start pulse. Stages return done 10, 20 and 30 cycles after their start pulses. Required: conv_start, relu_start and pool_start each high 1 cycle in that order; done high exactly 1 cycle after pool_done; stage sequence 1,2,3,0; busy low afterward.
- In RELU, drive relu_r_addr=5, relu_w_addr=7, relu_w_d=-3 with en/we=1, and conv_w_en=1. Required: bram_a_addr=5, bram_b_addr=7, bram_b_d=-3; conv request absent from both ports.
- During CONV, pulse start and pool_done. Required: no state change and no extra start pulses.
- Assert reset in cycle 3 of POOL. Required: next cycle state IDLE, bram_*_en=0, done never pulses. A new start runs a full frame.
- In IDLE, assert all en/we inputs. Required: all BRAM outputs 0; bram_a_q=0x1234 appears on rd_q same cycle.
- With CONV_BUF_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold relu_done. Required: err pulses 16 cycles after RELU entry, state IDLE, no done.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the conv-buffer scheduler: FSM states, stage owner codes
// and the buffer address-width helper.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_RELU   = 3'd2,
        S_POOL   = 3'd3,
        S_FINISH = 3'd4
    } sched_state_t;

    localparam logic [1:0] STG_IDLE = 2'd0;
    localparam logic [1:0] STG_CONV = 2'd1;
    localparam logic [1:0] STG_RELU = 2'd2;
    localparam logic [1:0] STG_POOL = 2'd3;

    // Word address width of a CHANNELS x IMG x IMG feature-map buffer.
    function automatic int buf_addr_width(input int channels, input int img_size);
        return $clog2(channels * img_size * img_size);
    endfunction

endpackage

// File: rtl/bram_port_mux.sv
// Combinational owner-select for the shared conv-buffer BRAM ports.
// A port that the current owner does not use is driven to all zeros.
module bram_port_mux import cnn_pkg::*; #(
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  logic [1:0]    stage,
    input  logic [AW-1:0] conv_w_addr,
    input  logic          conv_w_en,
    input  logic          conv_w_we,
    input  logic [DW-1:0] conv_w_d,
    input  logic [AW-1:0] relu_r_addr,
    input  logic          relu_r_en,
    input  logic [AW-1:0] relu_w_addr,
    input  logic          relu_w_en,
    input  logic          relu_w_we,
    input  logic [DW-1:0] relu_w_d,
    input  logic [AW-1:0] pool_r_addr,
    input  logic          pool_r_en,
    output logic [AW-1:0] bram_a_addr,
    output logic          bram_a_en,
    output logic [AW-1:0] bram_b_addr,
    output logic          bram_b_en,
    output logic          bram_b_we,
    output logic [DW-1:0] bram_b_d
);

    always_comb begin
        bram_a_addr = '0;
        bram_a_en   = 1'b0;
        bram_b_addr = '0;
        bram_b_en   = 1'b0;
        bram_b_we   = 1'b0;
        bram_b_d    = '0;
        case (stage)
            STG_CONV: begin
                bram_b_addr = conv_w_addr;
                bram_b_en   = conv_w_en;
                bram_b_we   = conv_w_we;
                bram_b_d    = conv_w_d;
            end
            STG_RELU: begin
                bram_a_addr = relu_r_addr;
                bram_a_en   = relu_r_en;
                bram_b_addr = relu_w_addr;
                bram_b_en   = relu_w_en;
                bram_b_we   = relu_w_we;
                bram_b_d    = relu_w_d;
            end
            STG_POOL: begin
                bram_a_addr = pool_r_addr;
                bram_a_en   = pool_r_en;
            end
            default: begin
                bram_a_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/conv_buf_sched.sv
// Sequences CONV -> RELU -> POOL over one shared conv-buffer BRAM.
// Optional per-stage watchdog with err output: CONV_BUF_SCHED_TIMEOUT_EN.
module conv_buf_sched import cnn_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65536
`endif
    , localparam int AW = buf_addr_width(CHANNELS, IMG_SIZE)
    , localparam int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [1:0]    stage,
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
    output logic          err,
`endif
    output logic          conv_start,
    output logic          relu_start,
    output logic          pool_start,
    input  logic          conv_done,
    input  logic          relu_done,
    input  logic          pool_done,
    input  logic [AW-1:0] conv_w_addr,
    input  logic          conv_w_en,
    input  logic          conv_w_we,
    input  logic [DW-1:0] conv_w_d,
    input  logic [AW-1:0] relu_r_addr,
    input  logic          relu_r_en,
    input  logic [AW-1:0] relu_w_addr,
    input  logic          relu_w_en,
    input  logic          relu_w_we,
    input  logic [DW-1:0] relu_w_d,
    input  logic [AW-1:0] pool_r_addr,
    input  logic          pool_r_en,
    output logic [AW-1:0] bram_a_addr,
    output logic          bram_a_en,
    output logic [AW-1:0] bram_b_addr,
    output logic          bram_b_en,
    output logic          bram_b_we,
    output logic [DW-1:0] bram_b_d,
    input  logic [DW-1:0] bram_a_q,
    output logic [DW-1:0] rd_q
);

    sched_state_t state;
    logic         accept;

`ifdef CONV_BUF_SCHED_TIMEOUT_EN
    localparam logic [31:0] WDOG_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wdog;
`endif

    // The start pulse register doubles as "first cycle in stage", which is
    // exactly the cycle where a done pulse must be ignored.
    always_comb begin
        accept = 1'b0;
        case (state)
            S_CONV:  accept = conv_done && !conv_start;
            S_RELU:  accept = relu_done && !relu_start;
            S_POOL:  accept = pool_done && !pool_start;
            default: accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            stage      <= STG_IDLE;
            conv_start <= 1'b0;
            relu_start <= 1'b0;
            pool_start <= 1'b0;
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
            err        <= 1'b0;
            wdog       <= '0;
`endif
        end else begin
            conv_start <= 1'b0;
            relu_start <= 1'b0;
            pool_start <= 1'b0;
            done       <= 1'b0;
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
            err        <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_CONV;
                        stage      <= STG_CONV;
                        busy       <= 1'b1;
                        conv_start <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (accept) begin
                        state      <= S_RELU;
                        stage      <= STG_RELU;
                        relu_start <= 1'b1;
                    end
                end
                S_RELU: begin
                    if (accept) begin
                        state      <= S_POOL;
                        stage      <= STG_POOL;
                        pool_start <= 1'b1;
                    end
                end
                S_POOL: begin
                    if (accept) begin
                        state <= S_FINISH;
                        stage <= STG_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    stage <= STG_IDLE;
                    busy  <= 1'b0;
                end
            endcase
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
            // Watchdog overrides the stage's own next-state when it expires.
            if (state inside {S_CONV, S_RELU, S_POOL}) begin
                if (accept) begin
                    wdog <= '0;
                end else if (wdog == WDOG_LIMIT) begin
                    state <= S_IDLE;
                    stage <= STG_IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    wdog  <= '0;
                end else begin
                    wdog <= wdog + 32'd1;
                end
            end else begin
                wdog <= '0;
            end
`endif
        end
    end

    bram_port_mux #(
        .DW (DW),
        .AW (AW)
    ) u_mux (
        .stage       (stage),
        .conv_w_addr (conv_w_addr),
        .conv_w_en   (conv_w_en),
        .conv_w_we   (conv_w_we),
        .conv_w_d    (conv_w_d),
        .relu_r_addr (relu_r_addr),
        .relu_r_en   (relu_r_en),
        .relu_w_addr (relu_w_addr),
        .relu_w_en   (relu_w_en),
        .relu_w_we   (relu_w_we),
        .relu_w_d    (relu_w_d),
        .pool_r_addr (pool_r_addr),
        .pool_r_en   (pool_r_en),
        .bram_a_addr (bram_a_addr),
        .bram_a_en   (bram_a_en),
        .bram_b_addr (bram_b_addr),
        .bram_b_en   (bram_b_en),
        .bram_b_we   (bram_b_we),
        .bram_b_d    (bram_b_d)
    );

    assign rd_q = bram_a_q;

endmodule

// File: tb/tb_conv_buf_sched.sv
// Bench for conv_buf_sched: frame timelines are computed arithmetically from
// the done delays, and every cycle's outputs are compared against them.
module tb_conv_buf_sched;

    localparam int DW  = 16;
    localparam int CH  = 8;
    localparam int IMG = 28;
    localparam int AW  = $clog2(CH * IMG * IMG);
    localparam int BIG = 32'h3fff_ffff;
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
    localparam int D_MAX      = 14;
`else
    localparam int D_MAX      = 30;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          done;
    logic          busy;
    logic [1:0]    stage;
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
    logic          err;
`endif
    logic          conv_start, relu_start, pool_start;
    logic          conv_done, relu_done, pool_done;
    logic [AW-1:0] conv_w_addr;
    logic          conv_w_en, conv_w_we;
    logic [DW-1:0] conv_w_d;
    logic [AW-1:0] relu_r_addr;
    logic          relu_r_en;
    logic [AW-1:0] relu_w_addr;
    logic          relu_w_en, relu_w_we;
    logic [DW-1:0] relu_w_d;
    logic [AW-1:0] pool_r_addr;
    logic          pool_r_en;
    logic [AW-1:0] bram_a_addr;
    logic          bram_a_en;
    logic [AW-1:0] bram_b_addr;
    logic          bram_b_en, bram_b_we;
    logic [DW-1:0] bram_b_d;
    logic [DW-1:0] bram_a_q;
    logic [DW-1:0] rd_q;

    conv_buf_sched #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .IMG_SIZE   (IMG)
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TB_TIMEOUT)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .stage       (stage),
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
        .err         (err),
`endif
        .conv_start  (conv_start),
        .relu_start  (relu_start),
        .pool_start  (pool_start),
        .conv_done   (conv_done),
        .relu_done   (relu_done),
        .pool_done   (pool_done),
        .conv_w_addr (conv_w_addr),
        .conv_w_en   (conv_w_en),
        .conv_w_we   (conv_w_we),
        .conv_w_d    (conv_w_d),
        .relu_r_addr (relu_r_addr),
        .relu_r_en   (relu_r_en),
        .relu_w_addr (relu_w_addr),
        .relu_w_en   (relu_w_en),
        .relu_w_we   (relu_w_we),
        .relu_w_d    (relu_w_d),
        .pool_r_addr (pool_r_addr),
        .pool_r_en   (pool_r_en),
        .bram_a_addr (bram_a_addr),
        .bram_a_en   (bram_a_en),
        .bram_b_addr (bram_b_addr),
        .bram_b_en   (bram_b_en),
        .bram_b_we   (bram_b_we),
        .bram_b_d    (bram_b_d),
        .bram_a_q    (bram_a_q),
        .rd_q        (rd_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame timeline model: cycle numbers where each stage starts, where
    // done is due, and where a reset/timeout forces the sequencer idle.
    int cyc       = 0;
    bit frame_on  = 1'b0;
    int start_cyc = -100;
    int c_conv    = -100;
    int c_relu    = -100;
    int c_pool    = -100;
    int c_done    = -100;
    int c_abort   = BIG;
    int c_rst     = -100;
    int c_err     = -100;
    int c_force   = -100;
    bit fixed_relu = 1'b0;
    bit idle_all   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic int owner(input int c);
        if (!frame_on || c < c_conv || c >= c_abort) return 0;
        if (c < c_relu) return 1;
        if (c < c_pool) return 2;
        if (c < c_done) return 3;
        return 0;
    endfunction

    function automatic bit in_frame(input int c);
        return frame_on && c >= c_conv && c <= c_done && c < c_abort;
    endfunction

    function automatic bit at(input int c, input int target);
        return frame_on && c == target && c < c_abort;
    endfunction

    // A spurious done is harmless when its stage is not the owner, or in
    // that stage's own start cycle.
    function automatic bit noise_ok(input int s, input int c);
        int first;
        first = (s == 1) ? c_conv : (s == 2) ? c_relu : c_pool;
        return (owner(c) != s) || (c == first);
    endfunction

    // driver: one clock cycle of stimulus, then the scoreboard comparison
    task automatic tick();
        int o;
        logic [AW-1:0] ea_addr, eb_addr;
        logic          ea_en, eb_en, eb_we;
        logic [DW-1:0] eb_d;
        @(posedge clk);
        cyc++;
        #1;
        o = owner(cyc);
        reset = (cyc <= 2) || (cyc == c_rst);
        start = (cyc == start_cyc) || (cyc == c_force) ||
                (in_frame(cyc) && $urandom_range(0, 5) == 0);
        conv_done = at(cyc, c_relu - 1) || (noise_ok(1, cyc) && $urandom_range(0, 7) == 0);
        relu_done = at(cyc, c_pool - 1) || (noise_ok(2, cyc) && $urandom_range(0, 7) == 0);
        pool_done = at(cyc, c_done - 1) || (cyc == c_force) ||
                    (noise_ok(3, cyc) && $urandom_range(0, 7) == 0);
        conv_w_addr = AW'($urandom_range(0, (1 << AW) - 1));
        conv_w_en   = 1'($urandom_range(0, 1));
        conv_w_we   = 1'($urandom_range(0, 1));
        conv_w_d    = DW'($urandom);
        relu_r_addr = AW'($urandom_range(0, (1 << AW) - 1));
        relu_r_en   = 1'($urandom_range(0, 1));
        relu_w_addr = AW'($urandom_range(0, (1 << AW) - 1));
        relu_w_en   = 1'($urandom_range(0, 1));
        relu_w_we   = 1'($urandom_range(0, 1));
        relu_w_d    = DW'($urandom);
        pool_r_addr = AW'($urandom_range(0, (1 << AW) - 1));
        pool_r_en   = 1'($urandom_range(0, 1));
        bram_a_q    = DW'($urandom);
        if (fixed_relu && o == 2) begin
            relu_r_addr = AW'(5);
            relu_r_en   = 1'b1;
            relu_w_addr = AW'(7);
            relu_w_en   = 1'b1;
            relu_w_we   = 1'b1;
            relu_w_d    = -16'sd3;
            conv_w_en   = 1'b1;
            conv_w_we   = 1'b1;
        end
        if (idle_all) begin
            conv_w_en = 1'b1; conv_w_we = 1'b1;
            relu_r_en = 1'b1; relu_w_en = 1'b1; relu_w_we = 1'b1;
            pool_r_en = 1'b1;
            bram_a_q  = 16'h1234;
        end
        @(negedge clk);
        ea_addr = '0; ea_en = 1'b0;
        eb_addr = '0; eb_en = 1'b0; eb_we = 1'b0; eb_d = '0;
        if (o == 1) begin
            eb_addr = conv_w_addr; eb_en = conv_w_en; eb_we = conv_w_we; eb_d = conv_w_d;
        end else if (o == 2) begin
            ea_addr = relu_r_addr; ea_en = relu_r_en;
            eb_addr = relu_w_addr; eb_en = relu_w_en; eb_we = relu_w_we; eb_d = relu_w_d;
        end else if (o == 3) begin
            ea_addr = pool_r_addr; ea_en = pool_r_en;
        end
        check("stage", 32'(stage), 32'(o));
        check("busy", 32'(busy), 32'(in_frame(cyc)));
        check("done", 32'(done), 32'(at(cyc, c_done)));
        check("conv_start", 32'(conv_start), 32'(at(cyc, c_conv)));
        check("relu_start", 32'(relu_start), 32'(at(cyc, c_relu)));
        check("pool_start", 32'(pool_start), 32'(at(cyc, c_pool)));
        check("bram_a_addr", 32'(bram_a_addr), 32'(ea_addr));
        check("bram_a_en", 32'(bram_a_en), 32'(ea_en));
        check("bram_b_addr", 32'(bram_b_addr), 32'(eb_addr));
        check("bram_b_en", 32'(bram_b_en), 32'(eb_en));
        check("bram_b_we", 32'(bram_b_we), 32'(eb_we));
        check("bram_b_d", 32'(bram_b_d), 32'(eb_d));
        check("rd_q", 32'(rd_q), 32'(bram_a_q));
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
        check("err", 32'(err), 32'(cyc == c_err));
`endif
    endtask

    // rst_off >= 0: reset during POOL cycle rst_off (0-based).
    // tmo: relu_done withheld so the watchdog fires.
    task automatic run_frame(input int d1, input int d2, input int d3,
                             input int rst_off, input bit tmo, input bit force_noise);
        int last;
        start_cyc = cyc + 1;
        c_conv    = start_cyc + 1;
        c_relu    = c_conv + d1 + 1;
        c_pool    = c_relu + (tmo ? 1000 : d2) + 1;
        c_done    = c_pool + d3 + 1;
        c_abort   = BIG;
        c_rst     = -100;
        c_err     = -100;
        c_force   = force_noise ? c_conv + 3 : -100;
        if (rst_off >= 0) begin
            c_rst   = c_pool + rst_off;
            c_abort = c_rst + 1;
        end
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
        if (tmo) begin
            c_abort = c_relu + TB_TIMEOUT;
            c_err   = c_abort;
        end
`endif
        frame_on = 1'b1;
        last = (c_abort < BIG) ? c_abort + 2 : c_done + 2;
        while (cyc < last) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        conv_done = 1'b0; relu_done = 1'b0; pool_done = 1'b0;
        conv_w_addr = '0; conv_w_en = 1'b0; conv_w_we = 1'b0; conv_w_d = '0;
        relu_r_addr = '0; relu_r_en = 1'b0;
        relu_w_addr = '0; relu_w_en = 1'b0; relu_w_we = 1'b0; relu_w_d = '0;
        pool_r_addr = '0; pool_r_en = 1'b0;
        bram_a_q = '0;

        repeat (4) tick();
        run_frame(10, (D_MAX >= 20) ? 20 : 12, (D_MAX >= 30) ? 30 : 14, -1, 1'b0, 1'b1);
        repeat (2) tick();
        fixed_relu = 1'b1;
        run_frame(3, 8, 4, -1, 1'b0, 1'b0);
        fixed_relu = 1'b0;
        run_frame(4, 5, 9, 2, 1'b0, 1'b0);
        run_frame(5, 5, 5, -1, 1'b0, 1'b0);
        idle_all = 1'b1;
        repeat (4) tick();
        idle_all = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, D_MAX), $urandom_range(1, D_MAX),
                      $urandom_range(1, D_MAX), -1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
`ifdef CONV_BUF_SCHED_TIMEOUT_EN
        run_frame(4, 0, 3, -1, 1'b1, 1'b0);
        run_frame(6, 7, 8, -1, 1'b0, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
